// File: rtl/usart_rx_pkg.sv
// usart_rx_pkg: shared state encoding, widths and default frame parameters for the usart blocks
package usart_rx_pkg;

    localparam int DATA_BITS_DEF   = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CPB_W           = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

endpackage

// File: rtl/usart_sync.sv
// usart_sync: multi-flop synchroniser for an asynchronous pin, idling high out of reset
module usart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // shift the pin through the chain; reset to 1 so an idle line never looks like a start bit
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/usart_rx.sv
// usart_rx: 8N1 serial receiver with mid-bit sampling, valid/ready byte output, framing and overrun pulses
module usart_rx
    import usart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DATA_BITS   = DATA_BITS_DEF
) (
    input  logic                 serial_clock,
    input  logic                 reset,
    input  logic [CPB_W-1:0]     clocks_per_bit,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int            BW   = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    state_e               state_q;
    logic [CPB_W-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 half_hit, bit_hit, accept;

    usart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i (serial_clock),
        .rst_i (reset),
        .d_i   (rx_pin),
        .q_o   (rx_s)
    );

    // bit-timing compares, LSB-first shift and whether a finished byte can be taken
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
        half_hit = cnt_q == (clocks_per_bit >> 1);
        bit_hit  = cnt_q == clocks_per_bit;
        accept   = !valid || ready;
    end

    // frame FSM with registered byte, valid and one-cycle error pulses
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            data_out      <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            if (valid && ready) valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) state_q <= S_START;
                end
                S_START: begin
                    if (half_hit) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s ? S_IDLE : S_DATA;
                    end else cnt_q <= cnt_d;
                end
                S_DATA: begin
                    if (bit_hit) begin
                        cnt_q   <= '0;
                        shift_q <= shift_d;
                        bit_q   <= bit_q == LAST ? '0 : bit_q + 1'b1;
                        if (bit_q == LAST) state_q <= S_STOP;
                    end else cnt_q <= cnt_d;
                end
                S_STOP: begin
                    if (bit_hit) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            if (accept) begin
                                data_out <= shift_q;
                                valid    <= 1'b1;
                            end else overrun <= 1'b1;
                        end else begin
                            framing_error <= 1'b1;
                            state_q       <= S_BREAK;
                        end
                    end else cnt_q <= cnt_d;
                end
                S_BREAK: begin
                    cnt_q <= '0;
                    if (rx_s) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = state_q != S_IDLE;

endmodule

// File: tb/tb_usart_rx.sv
// tb_usart_rx: directed frames against usart_rx with hand-computed expectations
module tb_usart_rx;

    logic        serial_clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] clocks_per_bit = 12'd7;
    logic        rx_pin = 1'b1;
    logic        ready = 1'b1;
    logic [7:0]  data_out;
    logic        valid, busy, framing_error, overrun;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, fe_cnt = 0, ov_cnt = 0, vhi_cnt = 0, busy_cnt = 0, rise_cyc = -1;
    int start, fe0, ov0, vh0, bz0;
    logic vprev = 1'b0;
    logic [7:0] rxq[$];
    logic [7:0] lb_bytes [3] = '{8'h00, 8'hFF, 8'hA5};
    logic [11:0] lb_cpb [2] = '{12'h001, 12'h00F};

    usart_rx dut (
        .serial_clock   (serial_clock),
        .reset          (reset),
        .clocks_per_bit (clocks_per_bit),
        .rx_pin         (rx_pin),
        .data_out       (data_out),
        .valid          (valid),
        .ready          (ready),
        .busy           (busy),
        .framing_error  (framing_error),
        .overrun        (overrun)
    );

    always #5 serial_clock = ~serial_clock;

    always @(posedge serial_clock) cyc <= cyc + 1;

    always @(negedge serial_clock) begin
        if (!reset) begin
            fe_cnt   <= fe_cnt + int'(framing_error);
            ov_cnt   <= ov_cnt + int'(overrun);
            vhi_cnt  <= vhi_cnt + int'(valid);
            busy_cnt <= busy_cnt + int'(busy);
            if (valid && !vprev) begin
                rxq.push_back(data_out);
                rise_cyc <= cyc;
            end
            vprev <= valid;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge serial_clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        int p;
        p = int'(clocks_per_bit) + 1;
        rx_pin = 1'b0;
        tick(p);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            tick(p);
        end
        rx_pin = stop;
        tick(p);
        rx_pin = 1'b1;
    endtask

    task automatic take(input string tag, input logic [7:0] exp);
        logic [8:0] v;
        v = 9'h100;
        if (rxq.size() != 0) v = {1'b0, rxq.pop_front()};
        chk(tag, 32'(v), 32'(exp));
    endtask

    task automatic snap();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        vh0 = vhi_cnt;
        bz0 = busy_cnt;
    endtask

    initial begin
        tick(3);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fe", 32'(framing_error), 0);
        chk("rst_ov", 32'(overrun), 0);
        reset = 1'b0;
        tick(4);

        // 0xAA at 8 clocks/bit: pin low after edge E, rx_s low from E+2, first seen at E+3, valid rises 76 edges later
        snap();
        start = cyc;
        send(8'hAA, 1'b1);
        tick(5);
        chk("aa_latency", 32'(rise_cyc - start), 79);
        take("aa_data", 8'hAA);
        chk("aa_valid_len", 32'(vhi_cnt - vh0), 1);
        chk("aa_fe", 32'(fe_cnt - fe0), 0);
        chk("aa_ov", 32'(ov_cnt - ov0), 0);

        // 3-cycle glitch: START from edge E+3 to E+7 where counter==3 sees the line high again
        snap();
        rx_pin = 1'b0;
        tick(3);
        rx_pin = 1'b1;
        tick(12);
        chk("gl_busy_cycles", 32'(busy_cnt - bz0), 4);
        chk("gl_busy", 32'(busy), 0);
        chk("gl_no_byte", 32'(rxq.size()), 0);
        chk("gl_fe", 32'(fe_cnt - fe0), 0);

        // 0x55 with a low stop bit and a held-low line, then a clean 0x3C
        snap();
        send(8'h55, 1'b0);
        rx_pin = 1'b0;
        tick(40);
        chk("fe_pulse", 32'(fe_cnt - fe0), 1);
        chk("fe_busy_break", 32'(busy), 1);
        chk("fe_valid", 32'(valid), 0);
        chk("fe_no_byte", 32'(rxq.size()), 0);
        rx_pin = 1'b1;
        tick(6);
        chk("fe_busy_idle", 32'(busy), 0);
        send(8'h3C, 1'b1);
        tick(5);
        take("fe_next_data", 8'h3C);
        chk("fe_no_more", 32'(fe_cnt - fe0), 1);

        // consumer stalled: second byte is dropped with one overrun pulse
        snap();
        ready = 1'b0;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        tick(4);
        chk("ov_valid_held", 32'(valid), 1);
        chk("ov_data_kept", 32'(data_out), 32'h11);
        chk("ov_pulse", 32'(ov_cnt - ov0), 1);
        take("ov_first", 8'h11);
        chk("ov_one_byte", 32'(rxq.size()), 0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        chk("ov_accept", 32'(valid), 0);
        ready = 1'b1;
        tick(3);

        // reset lands while bit 4 of 0xF0 is being timed; the remaining bits are all high
        snap();
        fork
            send(8'hF0, 1'b1);
            begin
                tick(45);
                reset = 1'b1;
                tick(1);
                chk("mr_busy", 32'(busy), 0);
                chk("mr_valid", 32'(valid), 0);
                chk("mr_data", 32'(data_out), 0);
                chk("mr_fe", 32'(framing_error), 0);
                chk("mr_ov", 32'(overrun), 0);
                reset = 1'b0;
            end
        join
        tick(5);
        chk("mr_no_byte", 32'(rxq.size()), 0);
        send(8'h0F, 1'b1);
        tick(5);
        take("mr_next_data", 8'h0F);
        chk("mr_no_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 0);

        // loopback through a transmitter model; 1 is the shortest period where start confirmation stays inside the start bit
        foreach (lb_cpb[c]) begin
            snap();
            clocks_per_bit = lb_cpb[c];
            foreach (lb_bytes[i]) begin
                send(lb_bytes[i], 1'b1);
                tick(2);
            end
            tick(int'(clocks_per_bit) + 6);
            foreach (lb_bytes[i]) take($sformatf("lb_%0d_%0d", c, i), lb_bytes[i]);
            chk($sformatf("lb_%0d_err", c), 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
